// File: rtl/timer_array.sv
// timer_array: NUM_CH-channel countdown timer, one-shot/auto-reload, masked sticky W1C interrupts.
// Define TIMER_PRESCALE_EN to add the shared prescaler at global offset +0x4.

module timer_chan #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             ctrl_we,
    input  logic             preset_we,
    input  logic             pend_clr,
    input  logic [31:0]      din,
    output logic [3:0]       ctrl,
    output logic [WIDTH-1:0] preset,
    output logic [WIDTH-1:0] count,
    output logic             pending
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

    state_t state;
    logic   en;
    logic   auto_rl;

    assign en      = ctrl[0];
    assign auto_rl = (ctrl[2:1] == 2'b01);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            ctrl    <= '0;
            preset  <= '0;
            count   <= '0;
            pending <= 1'b0;
        end else begin
            if (pend_clr) pending <= 1'b0;
            // A hardware expiry below overrides a same-edge W1C clear.
            case (state)
                S_IDLE: if (en) state <= S_LOAD;
                S_LOAD: begin
                    count <= preset;
                    state <= S_CNT;
                end
                S_CNT: begin
                    if (!en) begin
                        state <= S_IDLE;
                    end else if (tick) begin
                        if (count > WIDTH'(1)) begin
                            count <= count - WIDTH'(1);
                        end else begin
                            count   <= '0;
                            state   <= S_INT;
                            pending <= 1'b1;
                        end
                    end
                end
                S_INT: begin
                    if (!auto_rl) begin
                        ctrl[0] <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        state <= en ? S_LOAD : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (preset_we) preset <= din[WIDTH-1:0];
            // Placed last so a CPU write beats the one-shot EN clear.
            if (ctrl_we) ctrl <= din[3:0];
        end
    end
endmodule

module timer_array #(
    parameter int NUM_CH = 2,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] Addr,
    input  logic              WE,
    input  logic [31:0]       Din,
    output logic [31:0]       Dout,
    output logic [NUM_CH-1:0] irq_vec,
    output logic              IRQ
);
    localparam int BLK_W = ADDR_W - 4;

    logic [BLK_W-1:0]               blk;
    logic [1:0]                     sub;
    logic                           glb_sel;
    logic                           tick;
    logic                           unused_addr;
    logic [NUM_CH-1:0][3:0]         ctrl;
    logic [NUM_CH-1:0][WIDTH-1:0]   preset;
    logic [NUM_CH-1:0][WIDTH-1:0]   count;
    logic [NUM_CH-1:0]              pending;
    logic [NUM_CH-1:0]              ctrl_we;
    logic [NUM_CH-1:0]              preset_we;
    logic [NUM_CH-1:0]              pend_clr;

    assign blk         = Addr[ADDR_W-1:4];
    assign sub         = Addr[3:2];
    assign unused_addr = ^Addr[1:0];
    assign glb_sel     = (blk == BLK_W'(NUM_CH));
    assign pend_clr    = (WE && glb_sel && sub == 2'd0) ? Din[NUM_CH-1:0] : '0;

`ifdef TIMER_PRESCALE_EN
    logic [15:0] prescale;
    logic [15:0] pcnt;
    logic        presc_we;

    assign presc_we = WE && glb_sel && (sub == 2'd1);
    assign tick     = (pcnt == prescale);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale <= '0;
            pcnt     <= '0;
        end else if (presc_we) begin
            prescale <= Din[15:0];
            pcnt     <= '0;
        end else begin
            pcnt <= tick ? 16'd0 : pcnt + 16'd1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign ctrl_we[c]   = WE && (blk == BLK_W'(c)) && (sub == 2'd0);
        assign preset_we[c] = WE && (blk == BLK_W'(c)) && (sub == 2'd1);
        assign irq_vec[c]   = pending[c] & ctrl[c][3];

        timer_chan #(.WIDTH(WIDTH)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .tick      (tick),
            .ctrl_we   (ctrl_we[c]),
            .preset_we (preset_we[c]),
            .pend_clr  (pend_clr[c]),
            .din       (Din),
            .ctrl      (ctrl[c]),
            .preset    (preset[c]),
            .count     (count[c]),
            .pending   (pending[c])
        );
    end

    assign IRQ = |irq_vec;

    always_comb begin
        Dout = '0;
        if (glb_sel) begin
            case (sub)
                2'd0:    Dout[NUM_CH-1:0] = pending;
`ifdef TIMER_PRESCALE_EN
                2'd1:    Dout[15:0] = prescale;
`endif
                default: Dout = '0;
            endcase
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (int'(blk) == c) begin
                    case (sub)
                        2'd0:    Dout[3:0]       = ctrl[c];
                        2'd1:    Dout[WIDTH-1:0] = preset[c];
                        2'd2:    Dout[WIDTH-1:0] = count[c];
                        default: Dout = '0;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_timer_array.sv
// Bench for timer_array: cycle reference model checked every cycle under random register
// traffic, plus directed sequences with hand-computed expectations.
module tb_timer_array;
    localparam int NCH = 2;
    localparam int W   = 32;
    localparam int AW  = 8;
    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_RUN = 2, PH_EXP = 3;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] Addr  = '0;
    logic          WE    = 1'b0;
    logic [31:0]   Din   = '0;
    logic [31:0]   Dout;
    logic [NCH-1:0] irq_vec;
    logic          IRQ;

    int total = 0;
    int bad   = 0;

    timer_array #(.NUM_CH(NCH), .WIDTH(W), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din),
        .Dout(Dout), .irq_vec(irq_vec), .IRQ(IRQ)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [3:0]     m_ctrl   [NCH];
    logic [31:0]    m_preset [NCH];
    logic [31:0]    m_count  [NCH];
    int             m_ph     [NCH];
    logic [NCH-1:0] m_pend;
    logic [15:0]    m_presc;
    int             m_pc;

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_ctrl[c] = '0; m_preset[c] = '0; m_count[c] = '0; m_ph[c] = PH_IDLE;
        end
        m_pend = '0; m_presc = '0; m_pc = 0;
    endfunction

    function automatic void model_step();
        bit tick;
        int blk, sub;
        logic [NCH-1:0] set_m, clr_m;
        if (!reset) begin
            model_reset();
            return;
        end
`ifdef TIMER_PRESCALE_EN
        tick = (m_pc == int'(m_presc));
`else
        tick = 1'b1;
`endif
        set_m = '0; clr_m = '0;
        for (int c = 0; c < NCH; c++) begin
            bit en = m_ctrl[c][0];
            case (m_ph[c])
                PH_IDLE: if (en) m_ph[c] = PH_LOAD;
                PH_LOAD: begin m_count[c] = m_preset[c]; m_ph[c] = PH_RUN; end
                PH_RUN: begin
                    if (!en) m_ph[c] = PH_IDLE;
                    else if (tick) begin
                        if (m_count[c] > 1) m_count[c] = m_count[c] - 1;
                        else begin m_count[c] = 0; m_ph[c] = PH_EXP; set_m[c] = 1'b1; end
                    end
                end
                default: begin
                    if (m_ctrl[c][2:1] != 2'b01) begin m_ctrl[c][0] = 1'b0; m_ph[c] = PH_IDLE; end
                    else m_ph[c] = en ? PH_LOAD : PH_IDLE;
                end
            endcase
        end
        blk = int'(Addr[7:4]);
        sub = int'(Addr[3:2]);
        if (WE) begin
            if (blk < NCH && sub == 0) m_ctrl[blk]   = Din[3:0];
            if (blk < NCH && sub == 1) m_preset[blk] = Din;
            if (blk == NCH && sub == 0) clr_m = Din[NCH-1:0];
        end
        m_pend = (m_pend & ~clr_m) | set_m;
`ifdef TIMER_PRESCALE_EN
        if (WE && blk == NCH && sub == 1) begin m_presc = Din[15:0]; m_pc = 0; end
        else m_pc = tick ? 0 : m_pc + 1;
`endif
    endfunction

    function automatic logic [31:0] exp_dout(logic [7:0] a);
        int blk = int'(a[7:4]);
        int sub = int'(a[3:2]);
        logic [31:0] v = '0;
        if (blk < NCH) begin
            if (sub == 0)      v = {28'b0, m_ctrl[blk]};
            else if (sub == 1) v = m_preset[blk];
            else if (sub == 2) v = m_count[blk];
        end else if (blk == NCH) begin
            if (sub == 0) v = {{(32-NCH){1'b0}}, m_pend};
`ifdef TIMER_PRESCALE_EN
            else if (sub == 1) v = {16'b0, m_presc};
`endif
        end
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_irq();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_pend[c] & m_ctrl[c][3];
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("model_dout", Dout, exp_dout(Addr));
        chk("model_irq_vec", 32'(irq_vec), 32'(exp_irq()));
        chk("model_irq", 32'(IRQ), 32'(|exp_irq()));
    endtask

    // one clock: compare on the falling edge, advance the model on the rising edge
    task automatic cyc();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run(int n);
        repeat (n) cyc();
    endtask

    task automatic wr(int a, int d);
        Addr = 8'(a); Din = 32'(d); WE = 1'b1;
        cyc();
        WE = 1'b0;
    endtask

    task automatic rd(string name, int a, logic [31:0] exp);
        Addr = 8'(a);
        #1;
        chk(name, Dout, exp);
    endtask

    task automatic do_reset(bit check_regs);
        int regs [8] = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h20, 8'h24};
        reset = 1'b0; WE = 1'b0;
        #1;
        model_reset();
        if (check_regs) begin
            chk("rst_irq_now", 32'(IRQ), 0);
            chk("rst_irqvec_now", 32'(irq_vec), 0);
            foreach (regs[i]) rd("rst_reg", regs[i], 0);
        end
        cyc();
        reset = 1'b1;
    endtask

    function automatic logic [7:0] pick_addr();
        int k = $urandom_range(0, 9);
        int lo = $urandom_range(0, 3);
        if (k < 8) return 8'($urandom_range(0, NCH-1) * 16 + $urandom_range(0, 3) * 4 + lo);
        if (k == 8) return 8'(NCH * 16 + $urandom_range(0, 3) * 4 + lo);
        return 8'($urandom_range(NCH * 16 + 16, 255));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #1 reset = 1'b0;
        #1;
        rd("init_dout0", 0, 0);
        chk("init_irq", 32'(IRQ), 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int r = $urandom_range(0, 199);
            Addr = pick_addr();
            WE = 1'b0;
            if (r < 50) begin
                WE = 1'b1;
                Din = $urandom;
                if (Addr[3:2] == 2'd1) Din = 32'($urandom_range(0, 12));
                else if (Addr[7:4] < NCH && Addr[3:2] == 2'd0) Din[0] = ($urandom_range(0, 3) != 0);
            end
            if (r == 199) do_reset(0);
            else cyc();
        end
        WE = 1'b0;

        // reset mid-count, then IRQ must stay low
        wr(8'h04, 8); wr(8'h00, 9); run(3);
        do_reset(1);
        for (int i = 0; i < 20; i++) begin cyc(); chk("rst_quiet_irq", 32'(IRQ), 0); end

        // ch0 one-shot, PRESET=5
        do_reset(0);
        wr(8'h04, 5); wr(8'h00, 9);
        run(6); chk("os_e6_irq", 32'(IRQ), 0);
        run(1); chk("os_e7_irq", 32'(IRQ), 1); rd("os_e7_status", 8'h20, 1);
        run(1); rd("os_ctrl", 8'h00, 8); rd("os_count", 8'h08, 0);
        wr(8'h20, 1); chk("os_w1c_irq", 32'(IRQ), 0);

        // ch1 auto-reload, PRESET=3
        do_reset(0);
        wr(8'h14, 3); wr(8'h10, 8'hB);
        run(4); chk("ar_e4_irq", 32'(IRQ), 0);
        run(1); chk("ar_e5_irq", 32'(IRQ), 1);
        wr(8'h20, 2);
        run(3); rd("ar_e9_status", 8'h20, 0);
        run(1); rd("ar_e10_status", 8'h20, 2);
        wr(8'h10, 3); chk("ar_im0_irq", 32'(IRQ), 0); rd("ar_im0_status", 8'h20, 2);
        wr(8'h20, 2);
        run(2); rd("ar_e14_status", 8'h20, 0);
        run(1); rd("ar_e15_status", 8'h20, 2); chk("ar_e15_irq", 32'(IRQ), 0);

        // PRESET=0 expires at E3
        do_reset(0);
        wr(8'h04, 0); wr(8'h00, 9);
        run(2); chk("p0_e2_irq", 32'(IRQ), 0);
        run(1); chk("p0_e3_irq", 32'(IRQ), 1);

        // W1C on the expiry edge: set wins
        do_reset(0);
        wr(8'h04, 2); wr(8'h00, 8'hB);
        run(3); wr(8'h20, 1); rd("setwins_status", 8'h20, 1);
        wr(8'h20, 1); rd("w1c_status", 8'h20, 0);

        // freeze at COUNT=4, re-enable reloads
        do_reset(0);
        wr(8'h04, 10); wr(8'h00, 1);
        run(7); wr(8'h00, 0);
        run(5); rd("frozen_count", 8'h08, 4);
        wr(8'h00, 1); rd("reen_f0_count", 8'h08, 4);
        run(2); rd("reload_count", 8'h08, 10);

        // map: COUNT read-only, reserved/unmapped read 0, simultaneous expiry
        do_reset(0);
        wr(8'h08, 32'h55); rd("count_ro", 8'h08, 0);
        wr(8'h28, 32'hFFFF); rd("rsvd_28", 8'h28, 0);
        wr(8'hF0, 32'h1234); rd("unmapped_f0", 8'hF0, 0);
        wr(8'h04, 4); wr(8'h14, 3); wr(8'h00, 9); wr(8'h10, 9);
        run(4); chk("both_e5_vec", 32'(irq_vec), 0);
        run(1); chk("both_e6_vec", 32'(irq_vec), 3); chk("both_e6_irq", 32'(IRQ), 1);

        // prescaler
        do_reset(0);
`ifdef TIMER_PRESCALE_EN
        wr(8'h04, 2); wr(8'h24, 3); rd("presc_rd", 8'h24, 3);
        wr(8'h00, 1);
        run(2); rd("presc_p3_count", 8'h08, 2);
        run(1); rd("presc_p4_count", 8'h08, 1);
        run(3); rd("presc_p7_count", 8'h08, 1);
        run(1); rd("presc_p8_count", 8'h08, 0); rd("presc_p8_status", 8'h20, 1);
`else
        wr(8'h24, 3); rd("presc_absent", 8'h24, 0);
`endif
        run(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
